glitch_sequencer: RTL and testbench

//  Sequences the glitch datapath: holds the delay/width/repeat configuration and arms on request.
//  On a trigger rising edge it times a programmable delay, then emits glitch_out for a programmable width.
//  The delay+pulse pair repeats for a programmable count; done pulses once at the end.

---
 rtl/glitch_pkg.sv | 17 +
 rtl/glitch_sequencer_if.sv | 37 +++
 rtl/glitch_timer.sv | 30 +++
 rtl/glitch_sequencer.sv | 168 ++++++++++++++++
 tb/tb_glitch_sequencer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch sequencer slice.
//   - state_e   : FSM state encoding (IDLE, ARMED, DELAY, PULSE)
//   - CNT_W_DEF : default width of the delay/width counters
//   - REP_W_DEF : default width of the repeat counter
package glitch_pkg;

   localparam int CNT_W_DEF = 16;
   localparam int REP_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DELAY = 2'd2,
      PULSE = 2'd3
   } state_e;

endpackage

// File: rtl/glitch_sequencer_if.sv
// Bus between the host/UART command decoder and the glitch sequencer.
//   master : command side; drives cfg_we/cfg_delay/cfg_width/cfg_count, arm, abort, trigger
//   slave  : sequencer; drives armed, busy, glitch_out, done, cfg_err, state (debug view of the FSM)
// Handshake: there is no valid/ready pair. cfg_we, arm and abort are single-cycle
// strobes sampled on every rising clk edge and always consumed in that cycle; a
// cfg_we that cannot be honoured (FSM not in IDLE) is dropped and reported by a
// one-cycle cfg_err pulse instead of being stalled.
import glitch_pkg::*;

interface glitch_sequencer_if #(
   parameter int CNT_W = CNT_W_DEF,
   parameter int REP_W = REP_W_DEF
);
   logic             cfg_we;
   logic [CNT_W-1:0] cfg_delay;
   logic [CNT_W-1:0] cfg_width;
   logic [REP_W-1:0] cfg_count;
   logic             arm;
   logic             abort;
   logic             trigger;
   logic             armed;
   logic             busy;
   logic             glitch_out;
   logic             done;
   logic             cfg_err;
   state_e           state;

   modport master (
      output cfg_we, cfg_delay, cfg_width, cfg_count, arm, abort, trigger,
      input  armed, busy, glitch_out, done, cfg_err, state
   );

   modport slave (
      input  cfg_we, cfg_delay, cfg_width, cfg_count, arm, abort, trigger,
      output armed, busy, glitch_out, done, cfg_err, state
   );
endinterface

// File: rtl/glitch_timer.sv
// Loadable down-counter shared by the delay and pulse-width phases.
//   clk, rst  : clock, synchronous active-high reset (count cleared)
//   load      : load load_val (takes priority over dec)
//   load_val  : value to load
//   dec       : decrement; ignored at zero so the count never wraps
//   zero      : count is zero
module glitch_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/glitch_sequencer.sv
// Glitch sequencer: holds delay/width/repeat configuration, arms on request and,
// on a trigger rising edge, emits cfg_count pulses of cfg_width cycles each,
// every pulse preceded by cfg_delay+1 low cycles. done pulses after the last one.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : glitch_sequencer_if slave modport (cfg/arm/abort/trigger in,
//              armed/busy/glitch_out/done/cfg_err/state out)
// Build option: define TRIG_SYNC_EN to pass trigger through a 2-flop
// synchronizer (adds 2 cycles of trigger latency) for asynchronous trigger pins.
module glitch_sequencer
   import glitch_pkg::*;
#(
   parameter int          CNT_W     = CNT_W_DEF,
   parameter int          REP_W     = REP_W_DEF,
   parameter int unsigned DEF_DELAY = 100,
   parameter int unsigned DEF_WIDTH = 1
) (
   input  logic               clk,
   input  logic               rst,
   glitch_sequencer_if.slave  bus
);
   state_e           state;
   logic [CNT_W-1:0] cfg_delay_r;
   logic [CNT_W-1:0] cfg_width_r;
   logic [REP_W-1:0] cfg_count_r;
   logic [REP_W-1:0] rep;
   logic             armed_r, busy_r, glitch_r, done_r, cfg_err_r;
   logic             trig_s, trig_q, trig_rise;
   logic             t_load, t_dec, t_zero;
   logic [CNT_W-1:0] t_val;
   logic [CNT_W-1:0] width_m1;
   logic [REP_W-1:0] rep_init;

`ifdef TRIG_SYNC_EN
   logic trig_m;
   always_ff @(posedge clk) begin
      if (rst) begin
         trig_m <= 1'b0;
         trig_s <= 1'b0;
      end else begin
         trig_m <= bus.trigger;
         trig_s <= trig_m;
      end
   end
`else
   assign trig_s = bus.trigger;
`endif

   // trig_q follows trig_s in every state, so a trigger already high when the
   // sequencer arms never counts as an edge.
   always_ff @(posedge clk) begin
      if (rst) trig_q <= 1'b0;
      else     trig_q <= trig_s;
   end
   assign trig_rise = trig_s & ~trig_q;

   // Zero width / zero count behave as one.
   assign width_m1 = (cfg_width_r == '0) ? '0 : cfg_width_r - CNT_W'(1);
   assign rep_init = (cfg_count_r == '0) ? '0 : cfg_count_r - REP_W'(1);

   // Timer control: the timer holds the remaining cycles of the current phase;
   // it is reloaded on every phase change and decremented otherwise.
   always_comb begin
      t_load = 1'b0;
      t_dec  = 1'b0;
      t_val  = cfg_delay_r;
      if (!bus.abort) begin
         case (state)
            ARMED: t_load = trig_rise;
            DELAY: begin
               if (t_zero) begin
                  t_load = 1'b1;
                  t_val  = width_m1;
               end else begin
                  t_dec = 1'b1;
               end
            end
            PULSE: begin
               if (t_zero) t_load = (rep != '0);
               else        t_dec  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   glitch_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (t_load),
      .load_val (t_val),
      .dec      (t_dec),
      .zero     (t_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         armed_r     <= 1'b0;
         busy_r      <= 1'b0;
         glitch_r    <= 1'b0;
         done_r      <= 1'b0;
         cfg_err_r   <= 1'b0;
         rep         <= '0;
         cfg_delay_r <= CNT_W'(DEF_DELAY);
         cfg_width_r <= CNT_W'(DEF_WIDTH);
         cfg_count_r <= REP_W'(1);
      end else begin
         done_r    <= 1'b0;
         cfg_err_r <= bus.cfg_we && (state != IDLE);
         // Configuration is only taken while idle so a running sequence never changes.
         if (bus.cfg_we && (state == IDLE)) begin
            cfg_delay_r <= bus.cfg_delay;
            cfg_width_r <= bus.cfg_width;
            cfg_count_r <= bus.cfg_count;
         end
         if (bus.abort) begin
            state    <= IDLE;
            armed_r  <= 1'b0;
            busy_r   <= 1'b0;
            glitch_r <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.arm) begin
                     state   <= ARMED;
                     armed_r <= 1'b1;
                  end
               end
               ARMED: begin
                  if (trig_rise) begin
                     state   <= DELAY;
                     armed_r <= 1'b0;
                     busy_r  <= 1'b1;
                     rep     <= rep_init;
                  end
               end
               DELAY: begin
                  if (t_zero) begin
                     state    <= PULSE;
                     glitch_r <= 1'b1;
                  end
               end
               PULSE: begin
                  if (t_zero) begin
                     glitch_r <= 1'b0;
                     if (rep != '0) begin
                        state <= DELAY;
                        rep   <= rep - REP_W'(1);
                     end else begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.armed      = armed_r;
   assign bus.busy       = busy_r;
   assign bus.glitch_out = glitch_r;
   assign bus.done       = done_r;
   assign bus.cfg_err    = cfg_err_r;
   assign bus.state      = state;
endmodule

// File: tb/tb_glitch_sequencer.sv
import glitch_pkg::*;

module tb_glitch_sequencer;

`ifdef TRIG_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   // Scoreboard entries per sampled cycle: {busy, glitch_out, done}
   logic [2:0] exp_q[$];

   glitch_sequencer_if #(.CNT_W(16), .REP_W(8)) bus ();

   glitch_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are then read 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Independent timing model, k = cycles after t0 (t0 = edge that samples the rise).
   // Pulse p starts at d+1+p*(w+d+1) and lasts w cycles; done follows the last one.
   function automatic logic [2:0] model(input int k, input int d, input int w, input int n);
      int   per;
      int   dk;
      int   s;
      logic g;
      per = w + d + 1;
      dk  = n * per;
      g   = 1'b0;
      for (int p = 0; p < n; p++) begin
         s = d + 1 + p * per;
         if (k >= s && k < s + w) g = 1'b1;
      end
      return {(k < dk), g, (k == dk)};
   endfunction

   // ---------------- drivers ----------------
   task automatic do_run(input bit do_cfg, input bit do_arm, input int d, input int w,
                         input int n, input int len, input bit inject);
      int         we;
      int         ne;
      logic [2:0] e;
      we = (w == 0) ? 1 : w;
      ne = (n == 0) ? 1 : n;
      if (do_cfg) begin
         bus.cfg_delay = 16'(d);
         bus.cfg_width = 16'(w);
         bus.cfg_count = 8'(n);
      end
      if (do_cfg || do_arm) begin
         bus.cfg_we = do_cfg;
         bus.arm    = do_arm;
         tick();
         bus.cfg_we = 1'b0;
         bus.arm    = 1'b0;
         chk($sformatf("armed_before_d%0d", d), 32'(bus.armed), 32'd1);
      end
      bus.trigger = 1'b1;
      repeat (SYNC_LAT) tick();
      for (int k = 0; k < len; k++) exp_q.push_back(model(k, d, we, ne));
      for (int k = 0; k < len; k++) begin
         tick();
         e = exp_q.pop_front();
         chk($sformatf("run_d%0d_w%0d_n%0d_k%0d", d, w, n, k),
             32'({bus.busy, bus.glitch_out, bus.done}), 32'(e));
         if (inject) begin
            if (k == 1) begin
               bus.cfg_delay = 16'd2;
               bus.cfg_width = 16'd3;
               bus.cfg_count = 8'd2;
               bus.cfg_we    = 1'b1;
            end else if (k == 2) begin
               chk("cfg_err_pulse", 32'(bus.cfg_err), 32'd1);
               bus.cfg_we = 1'b0;
            end else if (k == 3) begin
               chk("cfg_err_clear", 32'(bus.cfg_err), 32'd0);
            end
         end
      end
   endtask

   task automatic idle_trigger();
      bus.trigger = 1'b0;
      repeat (SYNC_LAT + 2) tick();
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_state"},  32'(bus.state),      32'(IDLE));
      chk({tag, "_armed"},  32'(bus.armed),      32'd0);
      chk({tag, "_busy"},   32'(bus.busy),       32'd0);
      chk({tag, "_glitch"}, 32'(bus.glitch_out), 32'd0);
      chk({tag, "_done"},   32'(bus.done),       32'd0);
      chk({tag, "_cfgerr"}, 32'(bus.cfg_err),    32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      bus.cfg_we    = 1'b0;
      bus.cfg_delay = '0;
      bus.cfg_width = '0;
      bus.cfg_count = '0;
      bus.arm       = 1'b0;
      bus.abort     = 1'b0;
      bus.trigger   = 1'b0;
      repeat (3) tick();
      chk_quiet("reset");
      rst = 1'b0;
      tick();

      // D=3, W=2, N=1: pulse at t0+4..t0+5, done at t0+6
      do_run(1'b1, 1'b1, 3, 2, 1, 9, 1'b0);
      chk_quiet("after_case1");
      idle_trigger();

      // D=0, W=0, N=3: 1-cycle pulses at t0+1, +3, +5, single done at t0+6
      do_run(1'b1, 1'b1, 0, 0, 3, 9, 1'b0);
      idle_trigger();

      // Trigger already high while arming: must not start
      bus.trigger = 1'b1;
      repeat (4) tick();
      bus.arm = 1'b1;
      tick();
      bus.arm = 1'b0;
      repeat (6) tick();
      chk("held_high_busy",  32'(bus.busy),  32'd0);
      chk("held_high_armed", 32'(bus.armed), 32'd1);
      chk("held_high_state", 32'(bus.state), 32'(ARMED));
      bus.trigger = 1'b0;
      repeat (SYNC_LAT + 3) tick();
      do_run(1'b0, 1'b0, 0, 0, 3, 8, 1'b0);
      idle_trigger();

      // Abort in the middle of a D=3, W=4 pulse
      do_run(1'b1, 1'b1, 3, 4, 1, 5, 1'b0);
      bus.abort = 1'b1;
      bus.arm   = 1'b1;
      tick();
      bus.abort = 1'b0;
      bus.arm   = 1'b0;
      chk_quiet("abort");
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("abort_no_done_%0d", i), 32'(bus.done), 32'd0);
      end
      idle_trigger();

      // cfg_we during DELAY with D=9: dropped, flagged, timing unchanged
      do_run(1'b1, 1'b1, 9, 1, 1, 13, 1'b1);
      idle_trigger();
      do_run(1'b0, 1'b1, 9, 1, 1, 13, 1'b0);
      idle_trigger();

      // Reset during PULSE clears everything and restores default config
      do_run(1'b1, 1'b1, 3, 2, 1, 5, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_quiet("rst_mid_pulse");
      idle_trigger();
      do_run(1'b0, 1'b1, 100, 1, 1, 104, 1'b0);
      idle_trigger();

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
